// File: rtl/elevador_controle_if.sv
// Call buttons in, cabin status out, between a controller and its environment.
interface elevador_controle_if;
    logic       C1;
    logic       C2;
    logic       C3;
    logic       M;
    logic       A1;
    logic       A2;
    logic       A3;
    logic [1:0] andar;
    logic       dir;

    modport master (output C1, C2, C3, input M, A1, A2, A3, andar, dir);
    modport slave  (input C1, C2, C3, output M, A1, A2, A3, andar, dir);
endinterface

// File: rtl/elevador_controle.sv
// Three-floor elevator controller: latches calls, sweeps in the current
// direction, stops at requested floors and dwells for a fixed time.
//
// state | meaning
// IDLE  | stopped, no dwell pending; picks next action from registered calls
// MOVE  | travelling one floor segment (TRAVEL_CYCLES long)
// DWELL | stopped at a served floor (DWELL_CYCLES long)
module elevador_controle #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DWELL_CYCLES  = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    elevador_controle_if.slave bus
);
    localparam int CNT_MAX = (TRAVEL_CYCLES > DWELL_CYCLES) ? TRAVEL_CYCLES : DWELL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_t;

    state_t           state, state_nx;
    logic [1:0]       floor, floor_nx;
    logic             dir, dir_nx;
    logic [2:0]       req, req_nx;   // bit i holds the call for floor i+1
    logic [CNT_W-1:0] cnt, cnt_nx;

    function automatic logic [2:0] floor_mask(input logic [1:0] f);
        case (f)
            2'd1:    floor_mask = 3'b001;
            2'd2:    floor_mask = 3'b010;
            2'd3:    floor_mask = 3'b100;
            default: floor_mask = 3'b000;
        endcase
    endfunction

    function automatic logic beyond(input logic [2:0] r, input logic [1:0] f, input logic up);
        case (f)
            2'd1:    beyond = up ? |r[2:1] : 1'b0;
            2'd2:    beyond = up ? r[2] : r[0];
            2'd3:    beyond = up ? 1'b0 : |r[1:0];
            default: beyond = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            floor <= 2'd1;
            dir   <= 1'b1;
            req   <= 3'b000;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            floor <= floor_nx;
            dir   <= dir_nx;
            req   <= req_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        floor_nx = floor;
        dir_nx   = dir;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (|(req & floor_mask(floor))) begin
                    state_nx = DWELL;
                end else if (beyond(req, floor, dir)) begin
                    state_nx = MOVE;
                end else if (beyond(req, floor, !dir)) begin
                    state_nx = MOVE;
                    dir_nx   = !dir;
                end
            end
            MOVE: begin
                if (cnt == TRAVEL_LAST) begin
                    cnt_nx = '0;
                    if (dir && floor != 2'd3) begin
                        floor_nx = floor + 2'd1;
                    end else if (!dir && floor != 2'd1) begin
                        floor_nx = floor - 2'd1;
                    end
                    if (|(req & floor_mask(floor_nx))) begin
                        state_nx = DWELL;
                    end else if (beyond(req, floor_nx, dir)) begin
                        state_nx = MOVE;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DWELL: begin
                if (cnt == DWELL_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // The served floor's call is dropped on entry and swallowed for the whole stop.
        req_nx = req | {bus.C3, bus.C2, bus.C1};
        if (state == DWELL || state_nx == DWELL) begin
            req_nx = req_nx & ~floor_mask(floor_nx);
        end
    end

    assign bus.M     = (state == MOVE);
    assign bus.A1    = (state != MOVE) && (floor == 2'd1);
    assign bus.A2    = (state != MOVE) && (floor == 2'd2);
    assign bus.A3    = (state != MOVE) && (floor == 2'd3);
    assign bus.andar = floor;
    assign bus.dir   = dir;
endmodule

// File: tb/tb_elevador_controle.sv
// Self-checking bench for elevador_controle: fixed vector table, directed
// corner sequences and a randomized run against a timestamp-based model.
module tb_elevador_controle;
    localparam int T = 4;
    localparam int D = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    elevador_controle_if bus();

    elevador_controle #(.TRAVEL_CYCLES(T), .DWELL_CYCLES(D)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial forever #5 clock = ~clock;

    // Reference model: segment end times as absolute edge numbers, calls as a set.
    bit pend [1:3];
    int pos;
    bit mdir, moving, dwelling, was_dwelling;
    int ecount, seg_end;

    function automatic bit pend_beyond(input int f, input bit up);
        for (int k = 1; k <= 3; k++) begin
            if (pend[k] && ((up && k > f) || (!up && k < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [2:0] mdl_a();
        return moving ? 3'b000 : {pos == 1, pos == 2, pos == 3};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend = '{1'b0, 1'b0, 1'b0};
            pos = 1; mdir = 1'b1; moving = 1'b0; dwelling = 1'b0;
            ecount = 0; seg_end = 0;
        end else begin
            was_dwelling = dwelling;
            if (moving) begin
                if (ecount == seg_end) begin
                    pos = mdir ? pos + 1 : pos - 1;
                    if (pend[pos]) begin
                        moving = 1'b0; dwelling = 1'b1; seg_end = ecount + D;
                    end else if (pend_beyond(pos, mdir)) begin
                        seg_end = ecount + T;
                    end else begin
                        moving = 1'b0;
                    end
                end
            end else if (dwelling) begin
                if (ecount == seg_end) dwelling = 1'b0;
            end else if (pend[pos]) begin
                dwelling = 1'b1; seg_end = ecount + D;
            end else if (pend_beyond(pos, mdir)) begin
                moving = 1'b1; seg_end = ecount + T;
            end else if (pend_beyond(pos, !mdir)) begin
                mdir = !mdir; moving = 1'b1; seg_end = ecount + T;
            end
            pend[1] = pend[1] | bus.C1;
            pend[2] = pend[2] | bus.C2;
            pend[3] = pend[3] | bus.C3;
            if (was_dwelling || dwelling) pend[pos] = 1'b0;
            ecount++;
        end
    end

    typedef struct {
        logic [2:0] c;     // {C1,C2,C3}
        logic       m;
        logic [2:0] a;     // {A1,A2,A3}
        logic [1:0] fl;
        logic       d;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [2:0] c, input logic m, input logic [2:0] a,
                       input logic [1:0] fl, input logic d, input int n);
        vec_t v;
        v.c = c; v.m = m; v.a = a; v.fl = fl; v.d = d;
        repeat (n) tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic m, input logic [2:0] a,
                       input logic [1:0] fl, input logic d);
        logic [6:0] got, exp;
        got = {bus.M, bus.A1, bus.A2, bus.A3, bus.andar, bus.dir};
        exp = {m, a, fl, d};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got M=%b A=%b andar=%0d dir=%b, expected M=%b A=%b andar=%0d dir=%b",
                     nm, got[6], got[5:3], got[2:1], got[0], m, a, fl, d);
        end
    endtask

    task automatic cyc(input logic [2:0] c);
        {bus.C1, bus.C2, bus.C3} = c;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run(input int n);
        repeat (n) cyc(3'b000);
    endtask

    task automatic do_reset();
        {bus.C1, bus.C2, bus.C3} = 3'b000;
        reset_n = 1'b0;
        #1 chk("reset", 1'b0, 3'b100, 2'd1, 1'b1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        // Floor 1 -> 3 on a C3 pulse, then back to 1 on a C1 pulse.
        add(3'b001, 1'b0, 3'b100, 2'd1, 1'b1, 1);
        add(3'b000, 1'b1, 3'b000, 2'd1, 1'b1, 4);
        add(3'b000, 1'b1, 3'b000, 2'd2, 1'b1, 4);
        add(3'b000, 1'b0, 3'b001, 2'd3, 1'b1, 5);
        add(3'b100, 1'b0, 3'b001, 2'd3, 1'b1, 1);
        add(3'b000, 1'b1, 3'b000, 2'd3, 1'b0, 4);
        add(3'b000, 1'b1, 3'b000, 2'd2, 1'b0, 4);
        add(3'b000, 1'b0, 3'b100, 2'd1, 1'b0, 4);

        #2 do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].c);
            chk($sformatf("tbl%0d", i), tbl[i].m, tbl[i].a, tbl[i].fl, tbl[i].d);
        end

        // Call at own floor dwells in place; a repeat call during the dwell is swallowed.
        do_reset();
        cyc(3'b100); chk("s1_idle",    1'b0, 3'b100, 2'd1, 1'b1);
        cyc(3'b000); chk("s1_dwell1",  1'b0, 3'b100, 2'd1, 1'b1);
        cyc(3'b100); chk("s1_dwell2",  1'b0, 3'b100, 2'd1, 1'b1);
        cyc(3'b001); chk("s1_dwell3",  1'b0, 3'b100, 2'd1, 1'b1);
        cyc(3'b000); chk("s1_idle2",   1'b0, 3'b100, 2'd1, 1'b1);
        cyc(3'b000); chk("s1_depart",  1'b1, 3'b000, 2'd1, 1'b1);

        // Intermediate stop at floor 2 requested mid-travel.
        do_reset();
        cyc(3'b001); chk("s2_idle",    1'b0, 3'b100, 2'd1, 1'b1);
        cyc(3'b000); chk("s2_move1",   1'b1, 3'b000, 2'd1, 1'b1);
        cyc(3'b000);
        cyc(3'b010); chk("s2_move3",   1'b1, 3'b000, 2'd1, 1'b1);
        cyc(3'b000); chk("s2_move4",   1'b1, 3'b000, 2'd1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(3'b000); chk($sformatf("s2_dwell%0d", k), 1'b0, 3'b010, 2'd2, 1'b1);
        end
        cyc(3'b000); chk("s2_idle_f2", 1'b0, 3'b010, 2'd2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(3'b000); chk($sformatf("s2_move_b%0d", k), 1'b1, 3'b000, 2'd2, 1'b1);
        end
        cyc(3'b000); chk("s2_arrive3", 1'b0, 3'b001, 2'd3, 1'b1);

        // At floor 2 heading up, simultaneous C1+C3: up first, then down.
        do_reset();
        cyc(3'b010);
        run(7);
        cyc(3'b000); chk("s3_idle_f2", 1'b0, 3'b010, 2'd2, 1'b1);
        cyc(3'b101); chk("s3_latch",   1'b0, 3'b010, 2'd2, 1'b1);
        cyc(3'b000); chk("s3_up",      1'b1, 3'b000, 2'd2, 1'b1);
        run(3);
        cyc(3'b000); chk("s3_at3",     1'b0, 3'b001, 2'd3, 1'b1);
        run(3);
        cyc(3'b000); chk("s3_down",    1'b1, 3'b000, 2'd3, 1'b0);
        run(3);
        cyc(3'b000); chk("s3_pass2",   1'b1, 3'b000, 2'd2, 1'b0);
        run(3);
        cyc(3'b000); chk("s3_at1",     1'b0, 3'b100, 2'd1, 1'b0);

        // Reset in the third travel cycle drops the pending call.
        do_reset();
        cyc(3'b001);
        run(2);
        cyc(3'b000); chk("s4_move3",   1'b1, 3'b000, 2'd1, 1'b1);
        reset_n = 1'b0;
        #1 chk("s4_reset", 1'b0, 3'b100, 2'd1, 1'b1);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc(3'b000); chk($sformatf("s4_stay%0d", k), 1'b0, 3'b100, 2'd1, 1'b1);
        end

        // Random calls and occasional resets against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.C1 = ($urandom_range(0, 7) == 0);
            bus.C2 = ($urandom_range(0, 7) == 0);
            bus.C3 = ($urandom_range(0, 7) == 0);
            if (reset_n && $urandom_range(0, 299) == 0) reset_n = 1'b0;
            else reset_n = 1'b1;
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("rand%0d", i), moving, mdl_a(), 2'(pos), mdir);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
